bit_op_pipe: RTL and testbench
==============================

// Module: bit_op_pipe
// PURPOSE
//   Parametrised, registered bitwise-logic unit: next generation of the 8-bit
//   combinational bitwise-operator block. Selectable op, valid/ready handshake,
//   one output register stage, optional accumulate mode (operand B taken from an
//   internal accumulator), reduction flags and population count of the result.
//   Sits between operand source and any consumer that can apply backpressure.
// PARAMETERS
//   WIDTH     8       operand/result width in bits (>=2)
//   ACC_INIT  0       accumulator value after reset or i_acc_clr (WIDTH bits)
//   CNT_W     $clog2(WIDTH+1)  derived (localparam): width of o_popcnt
// PORTS
//   i_clk      in   1        clock; all state updates on rising edge
//   i_rst_n    in   1        reset, asynchronous assert, active-low
//   i_valid    in   1        input transfer request
//   o_ready    out  1        unit can accept input this cycle
//   i_op       in   3        operation select (table below)
//   i_acc_en   in   1        1: operand B := accumulator, result written back
//   i_acc_clr  in   1        load ACC_INIT into accumulator (sampled w/o handshake)
//   i_a        in   WIDTH    operand A
//   i_b        in   WIDTH    operand B (ignored when i_acc_en=1)
//   o_valid    out  1        result valid
//   i_ready    in   1        downstream accepts result
//   o_result   out  WIDTH    registered result
//   o_red_and  out  1        &o_result
//   o_red_or   out  1        |o_result
//   o_red_xor  out  1        ^o_result (parity)
//   o_popcnt   out  CNT_W    number of 1 bits in o_result
// BEHAVIOUR
// - One clock, i_clk; reset is asynchronous and active-low (i_rst_n).
// - Reset: o_valid=0, o_result=0, o_red_*=0, o_popcnt=0, accumulator=ACC_INIT.
//   Reset mid-transfer drops the held result; no partial state survives.
// - Op table (B = i_b, or accumulator when i_acc_en=1):
//   0 ~A | 1 A&B | 2 A|B | 3 A^B | 4 A~^B | 5 ~(A&B) | 6 ~(A|B) | 7 A&~B.
// - Handshake: input accepted when i_valid && o_ready; output consumed when
//   o_valid && i_ready. o_ready = !o_valid || i_ready (combinational from
//   i_ready; no input-to-output combinational path otherwise).
// - Latency 1: accepted at edge N -> o_valid=1 with result after edge N.
//   Full throughput (one/cycle) when i_ready held 1.
// - Stall: o_valid && !i_ready -> o_result, flags, popcnt held stable; input
//   not accepted; i_a/i_b/i_op ignored.
// - Consume without new accept: o_valid clears next edge; o_result/flags keep
//   last value (don't-care to consumer).
// - Reductions and popcount computed from the value being registered and
//   registered together with it: all outputs coherent in the same cycle.
// - Accumulator: updated with the result on every accepted transfer with
//   i_acc_en=1; unchanged on transfers with i_acc_en=0 and on stalls.
// - i_acc_clr: accumulator := ACC_INIT at next edge, independent of handshake.
//   Same cycle as accepted i_acc_en transfer: clear applies first, i.e. B =
//   ACC_INIT and accumulator := op(A, ACC_INIT).
// - Back-to-back accumulate: transfer N+1 uses result of transfer N as B
//   (accumulator forwarded, no bubble).
// - Popcount range 0..WIDTH; all-ones result -> o_popcnt = WIDTH, no wrap.
// TESTING
// - Reset: drive i_rst_n=0 async mid-cycle -> o_valid=0, o_result=0, o_popcnt=0
//   immediately; after release first accept of op1 A=8'hF0 B=8'h3C -> 8'h30.
// - Op sweep (WIDTH=8) A=8'hA5 B=8'h0F: ops 0..7 -> 5A,05,AF,AA,55,FA,50,A0;
//   op 0 -> red_and=0 red_or=1 red_xor=0 popcnt=4.
// - Backpressure: 4 back-to-back inputs, i_ready=0 for 3 cycles after first
//   result -> o_result stable, o_ready=0, no input lost/duplicated, order kept.
// - Accumulate XOR: i_acc_clr then ops 3 with A=01,02,04,08 back-to-back ->
//   results 01,03,07,0F; final o_popcnt=4, o_red_xor=0.
// - Clear+accumulate same cycle: acc=8'hFF, i_acc_clr=1, op1 acc_en A=8'hFF ->
//   result 8'h00 (ACC_INIT=0); next acc_en op2 A=8'h01 -> 8'h01.
// - WIDTH=13 build: op0 A=0 -> result 13'h1FFF, popcnt=13, red_and=1.

Source files
------------

// File: rtl/bit_op_pipe_if.sv
// Handshake and operand/result bundle for bit_op_pipe.
// The slave modport is the unit's view; the master modport is the source/sink view.
interface bit_op_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             i_valid;
  logic             o_ready;
  logic [2:0]       i_op;
  logic             i_acc_en;
  logic             i_acc_clr;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_red_and;
  logic             o_red_or;
  logic             o_red_xor;
  logic [CNT_W-1:0] o_popcnt;

  modport slave (
    input  i_valid, i_op, i_acc_en, i_acc_clr, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_red_and, o_red_or, o_red_xor, o_popcnt
  );

  modport master (
    output i_valid, i_op, i_acc_en, i_acc_clr, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_red_and, o_red_or, o_red_xor, o_popcnt
  );
endinterface

// File: rtl/bit_op_pipe.sv
// Registered bitwise-logic unit with valid/ready handshake, optional accumulator
// operand, and reduction flags / popcount registered alongside the result.
module bit_op_pipe #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bit_op_pipe_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_XNOR = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_ANDN = 3'd7
  } op_e;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             red_and_q, red_and_d;
  logic             red_or_q, red_or_d;
  logic             red_xor_q, red_xor_d;
  logic [CNT_W-1:0] popcnt_q, popcnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] op_res;
  logic [CNT_W-1:0] cnt_chain [WIDTH+1];

  assign ready  = !valid_q || bus.i_ready;
  assign accept = bus.i_valid && ready;

  // A same-cycle clear takes priority, so the operand sees ACC_INIT directly.
  assign acc_eff   = bus.i_acc_clr ? ACC_INIT : acc_q;
  assign operand_b = bus.i_acc_en ? acc_eff : bus.i_b;

  always_comb begin
    op_res = '0;
    case (op_e'(bus.i_op))
      OP_NOT:  op_res = ~bus.i_a;
      OP_AND:  op_res = bus.i_a & operand_b;
      OP_OR:   op_res = bus.i_a | operand_b;
      OP_XOR:  op_res = bus.i_a ^ operand_b;
      OP_XNOR: op_res = ~(bus.i_a ^ operand_b);
      OP_NAND: op_res = ~(bus.i_a & operand_b);
      OP_NOR:  op_res = ~(bus.i_a | operand_b);
      OP_ANDN: op_res = bus.i_a & ~operand_b;
      default: op_res = '0;
    endcase
  end

  assign cnt_chain[0] = '0;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_popcnt
      assign cnt_chain[gi+1] = cnt_chain[gi] + {{(CNT_W-1){1'b0}}, op_res[gi]};
    end
  endgenerate

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    red_and_d = red_and_q;
    red_or_d  = red_or_q;
    red_xor_d = red_xor_q;
    popcnt_d  = popcnt_q;
    acc_d     = acc_q;

    if (accept) begin
      valid_d   = 1'b1;
      result_d  = op_res;
      red_and_d = &op_res;
      red_or_d  = |op_res;
      red_xor_d = ^op_res;
      popcnt_d  = cnt_chain[WIDTH];
    end else if (bus.i_ready) begin
      valid_d = 1'b0;
    end

    // Write-back wins over a bare clear because op_res already folded the clear in.
    if (accept && bus.i_acc_en) begin
      acc_d = op_res;
    end else if (bus.i_acc_clr) begin
      acc_d = ACC_INIT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      red_and_q <= 1'b0;
      red_or_q  <= 1'b0;
      red_xor_q <= 1'b0;
      popcnt_q  <= '0;
      acc_q     <= ACC_INIT;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      red_and_q <= red_and_d;
      red_or_q  <= red_or_d;
      red_xor_q <= red_xor_d;
      popcnt_q  <= popcnt_d;
      acc_q     <= acc_d;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid_q;
  assign bus.o_result  = result_q;
  assign bus.o_red_and = red_and_q;
  assign bus.o_red_or  = red_or_q;
  assign bus.o_red_xor = red_xor_q;
  assign bus.o_popcnt  = popcnt_q;

endmodule

// File: tb/tb_bit_op_pipe.sv
// Scoreboard bench for bit_op_pipe: the driver queues hand-computed results,
// the monitor pops and compares on every consumed output.
module tb_bit_op_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_op_pipe_if #(.WIDTH(8))  bus8 ();
  bit_op_pipe_if #(.WIDTH(13)) bus13 ();

  bit_op_pipe #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst_n(rst_n), .bus(bus8));
  bit_op_pipe #(.WIDTH(13)) dut13 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus13));

  typedef struct {
    logic [7:0] res;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an output is consumed at the next edge when valid && ready here.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.o_valid && bus8.i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", bus8.o_result);
      end else begin
        e = exp_q.pop_front();
        $display("txn %s result=%02h popcnt=%0d and=%b or=%b xor=%b", e.name,
                 bus8.o_result, bus8.o_popcnt, bus8.o_red_and, bus8.o_red_or, bus8.o_red_xor);
        check({e.name, "_result"}, 32'(bus8.o_result), 32'(e.res));
        check({e.name, "_popcnt"}, 32'(bus8.o_popcnt), 32'($countones(e.res)));
        check({e.name, "_red_and"}, 32'(bus8.o_red_and), 32'(&e.res));
        check({e.name, "_red_or"}, 32'(bus8.o_red_or), 32'(|e.res));
        check({e.name, "_red_xor"}, 32'(bus8.o_red_xor), 32'(^e.res));
      end
    end
  end

  task automatic send(input string nm, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic en, input logic clr,
                      input logic [7:0] exp);
    int   n;
    exp_t e;
    n = 0;
    bus8.i_op      = op;
    bus8.i_a       = a;
    bus8.i_b       = b;
    bus8.i_acc_en  = en;
    bus8.i_acc_clr = clr;
    bus8.i_valid   = 1'b1;
    @(negedge clk);
    while (!bus8.o_ready) begin
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_accept_timeout: got o_ready=0 expected 1", nm);
        bus8.i_valid   = 1'b0;
        bus8.i_acc_clr = 1'b0;
        return;
      end
      @(negedge clk);
    end
    e.res  = exp;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus8.i_valid   = 1'b0;
    bus8.i_acc_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    bus8.i_acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus8.i_acc_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] held;
    int         n;
    bus8.i_valid = 0; bus8.i_op = 0; bus8.i_a = 0; bus8.i_b = 0;
    bus8.i_acc_en = 0; bus8.i_acc_clr = 0; bus8.i_ready = 1;
    bus13.i_valid = 0; bus13.i_op = 0; bus13.i_a = 0; bus13.i_b = 0;
    bus13.i_acc_en = 0; bus13.i_acc_clr = 0; bus13.i_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("por_valid", 32'(bus8.o_valid), 32'h0);
    check("por_result", 32'(bus8.o_result), 32'h0);
    check("por_popcnt", 32'(bus8.o_popcnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hold a result under backpressure, then reset asynchronously mid-cycle.
    bus8.i_ready = 1'b0;
    send("held", 3'd2, 8'h12, 8'h40, 1'b0, 1'b0, 8'h52);
    check("held_valid", 32'(bus8.o_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus8.o_valid), 32'h0);
    check("rst_result", 32'(bus8.o_result), 32'h0);
    check("rst_popcnt", 32'(bus8.o_popcnt), 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus8.i_ready = 1'b1;
    @(posedge clk);
    #1;
    send("post_rst_and", 3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30);

    send("op0", 3'd0, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'h5A);
    send("op1", 3'd1, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'h05);
    send("op2", 3'd2, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'hAF);
    send("op3", 3'd3, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'hAA);
    send("op4", 3'd4, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'h55);
    send("op5", 3'd5, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'hFA);
    send("op6", 3'd6, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'h50);
    send("op7", 3'd7, 8'hA5, 8'h0F, 1'b0, 1'b0, 8'hA0);

    fork
      begin
        send("bp0", 3'd3, 8'h11, 8'h0F, 1'b0, 1'b0, 8'h1E);
        send("bp1", 3'd3, 8'h22, 8'h0F, 1'b0, 1'b0, 8'h2D);
        send("bp2", 3'd3, 8'h33, 8'h0F, 1'b0, 1'b0, 8'h3C);
        send("bp3", 3'd3, 8'h44, 8'h0F, 1'b0, 1'b0, 8'h4B);
      end
      begin
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!(bus8.o_valid && bus8.o_result == 8'h1E) && n < 20);
        check("bp_first_seen", 32'(n < 20), 32'h1);
        bus8.i_ready = 1'b0;
        held = bus8.o_result;
        repeat (3) begin
          @(negedge clk);
          check("bp_stable", 32'(bus8.o_result), 32'(held));
          check("bp_ready_low", 32'(bus8.o_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus8.i_ready = 1'b1;
      end
    join

    pulse_clr();
    send("accx1", 3'd3, 8'h01, 8'hAA, 1'b1, 1'b0, 8'h01);
    send("accx2", 3'd3, 8'h02, 8'hAA, 1'b1, 1'b0, 8'h03);
    send("accx3", 3'd3, 8'h04, 8'hAA, 1'b1, 1'b0, 8'h07);
    send("accx4", 3'd3, 8'h08, 8'hAA, 1'b1, 1'b0, 8'h0F);
    // Plain transfer in between must leave the accumulator alone (still 0F).
    send("plain", 3'd1, 8'hFF, 8'h3C, 1'b0, 1'b0, 8'h3C);
    send("acc_ff", 3'd2, 8'hF0, 8'h00, 1'b1, 1'b0, 8'hFF);
    send("clr_and", 3'd1, 8'hFF, 8'h55, 1'b1, 1'b1, 8'h00);
    send("after_clr", 3'd2, 8'h01, 8'h55, 1'b1, 1'b0, 8'h01);

    bus13.i_valid = 1'b1;
    @(negedge clk);
    check("w13_ready", 32'(bus13.o_ready), 32'h1);
    @(posedge clk);
    #1;
    bus13.i_valid = 1'b0;
    $display("txn w13_op0 result=%04h popcnt=%0d", bus13.o_result, bus13.o_popcnt);
    check("w13_valid", 32'(bus13.o_valid), 32'h1);
    check("w13_result", 32'(bus13.o_result), 32'h1FFF);
    check("w13_popcnt", 32'(bus13.o_popcnt), 32'd13);
    check("w13_red_and", 32'(bus13.o_red_and), 32'h1);
    check("w13_red_xor", 32'(bus13.o_red_xor), 32'h1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
